mdu_issue_ctrl: RTL and testbench

Issue controller that sits between the E-stage decode and the multiply/divide unit (MDU). It accepts one MDU-class instruction at a time over a valid/ready handshake, registers its operands, and drives the MDU start/op/operand inputs. It tracks the expected MDU latency with its own down-counter, stalls the pipeline while the MDU is occupied, and flags any disagreement between its counter and the MDU `busy` line.

---
 rtl/mdu_issue_ctrl.sv | 116 +++++++++++
 tb/tb_mdu_issue_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_ctrl.sv
// Issue controller between E-stage decode and the multiply/divide unit.
// Optional macro MDU_CANCEL_EN lets a pipeline flush cancel an op before the MDU starts it.
module mdu_issue_ctrl #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_rs,
    input  logic [31:0] req_rt,
    output logic        req_ready,
    output logic        stall,
    input  logic        flush,
    output logic        mdu_start,
    output logic [3:0]  mdu_op,
    output logic [31:0] mdu_d1,
    output logic [31:0] mdu_d2,
    input  logic        mdu_busy,
    output logic        err_proto,
    output logic [31:0] busy_cycles
);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next;
    logic [3:0]  op_q;
    logic [31:0] rs_q, rt_q;
    logic        err_q;
    logic        accept, cancel, req_long, req_move, req_div, held_long, mismatch;

    // Flush is referenced in both builds; without cancellation it has no effect.
`ifdef MDU_CANCEL_EN
    assign cancel = flush;
`else
    assign cancel = flush & 1'b0;
`endif

    assign req_long  = (req_op >= 4'd1) && (req_op <= 4'd5);
    assign req_move  = (req_op == 4'd6) || (req_op == 4'd7);
    assign req_div   = (req_op == 4'd3) || (req_op == 4'd4);
    assign held_long = (op_q >= 4'd1) && (op_q <= 4'd5);
    assign mismatch  = mdu_busy != (state == RUN);
    assign stall     = req_valid & ~req_ready;
    assign err_proto = err_q | mismatch;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_ready  = 1'b0;
        accept     = 1'b0;
        mdu_start  = 1'b0;
        mdu_op     = 4'd0;
        mdu_d1     = 32'd0;
        mdu_d2     = 32'd0;
        case (state)
            IDLE: begin
                req_ready = ~cancel;
                accept    = req_valid & ~cancel;
                if (accept && req_long) begin
                    state_next = LAUNCH;
                    cnt_next   = req_div ? 8'(DIV_LAT) : 8'(MUL_LAT);
                end else if (accept && req_move) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                mdu_d1 = rs_q;
                mdu_d2 = rt_q;
                if (cancel) begin
                    state_next = IDLE;
                    cnt_next   = 8'd0;
                end else begin
                    mdu_op     = op_q;
                    mdu_start  = held_long;
                    state_next = held_long ? RUN : IDLE;
                end
            end
            RUN: begin
                cnt_next = cnt - 8'd1;
                // The counter alone sequences the op; mdu_busy is only cross-checked.
                if (cnt <= 8'd1) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            op_q        <= 4'd0;
            rs_q        <= 32'd0;
            rt_q        <= 32'd0;
            err_q       <= 1'b0;
            busy_cycles <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            err_q <= err_q | mismatch;
            if (accept && (req_long || req_move)) begin
                op_q <= req_op;
                rs_q <= req_rs;
                rt_q <= req_rt;
            end
            if (state == RUN) begin
                busy_cycles <= busy_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl with a small MDU busy model.
// Build with MDU_CANCEL_EN defined to exercise the flush-cancel feature.
module tb_mdu_issue_ctrl;

    localparam int unsigned MUL_LAT = 5;
    localparam int unsigned DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_rs, req_rt;
    logic        req_ready, stall, flush;
    logic        mdu_start;
    logic [3:0]  mdu_op;
    logic [31:0] mdu_d1, mdu_d2;
    logic        mdu_busy;
    logic        err_proto;
    logic [31:0] busy_cycles;
    logic        tie_low;
    logic [7:0]  mdu_cnt;

    int checks = 0;
    int errors = 0;

    mdu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt),
        .req_ready(req_ready), .stall(stall), .flush(flush),
        .mdu_start(mdu_start), .mdu_op(mdu_op), .mdu_d1(mdu_d1), .mdu_d2(mdu_d2),
        .mdu_busy(mdu_busy), .err_proto(err_proto), .busy_cycles(busy_cycles)
    );

    always #5 clk = ~clk;

    // MDU stand-in: busy for exactly LAT cycles after a start pulse, unless tied low.
    always @(posedge clk) begin
        if (reset)
            mdu_cnt <= 8'd0;
        else if (mdu_start)
            mdu_cnt <= ((mdu_op == 4'd3) || (mdu_op == 4'd4)) ? 8'(DIV_LAT) : 8'(MUL_LAT);
        else if (mdu_cnt != 8'd0)
            mdu_cnt <= mdu_cnt - 8'd1;
    end
    assign mdu_busy = (mdu_cnt != 8'd0) && !tie_low;

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        ready;
        logic        stl;
        logic        start;
        logic [3:0]  mop;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        err;
        logic [31:0] bc;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic fl);
        req_valid = v;
        req_op    = op;
        req_rs    = rs;
        req_rt    = rt;
        flush     = fl;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // MULT 7 * -3, trailing MFHI stall, MTHI write-through, consumed MFLO/NOP/unused codes
        vecs[0]  = '{1'b1, 4'd1, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd0};
        vecs[1]  = '{1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 4'd1, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'd0};
        vecs[2]  = '{1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd0};
        vecs[3]  = '{1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd1};
        vecs[4]  = '{1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd2};
        vecs[5]  = '{1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd3};
        vecs[6]  = '{1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd4};
        vecs[7]  = '{1'b1, 4'd6, 32'h1234_5678, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd5};
        vecs[8]  = '{1'b1, 4'd9, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 4'd6, 32'h1234_5678, 32'd0, 1'b0, 32'd5};
        vecs[9]  = '{1'b1, 4'd9, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd5};
        vecs[10] = '{1'b1, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd5};
        vecs[11] = '{1'b1, 4'd12, 32'd5, 32'd6, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd5};
        vecs[12] = '{1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd5};

        tie_low = 1'b0;
        doReset();
        checkOutput("reset.ready", 32'(req_ready), 32'd1);
        checkOutput("reset.start", 32'(mdu_start), 32'd0);
        checkOutput("reset.err", 32'(err_proto), 32'd0);
        checkOutput("reset.bc", busy_cycles, 32'd0);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b0);
            checkOutput($sformatf("v%0d.ready", i), 32'(req_ready), 32'(vecs[i].ready));
            checkOutput($sformatf("v%0d.stall", i), 32'(stall), 32'(vecs[i].stl));
            checkOutput($sformatf("v%0d.start", i), 32'(mdu_start), 32'(vecs[i].start));
            checkOutput($sformatf("v%0d.op", i), 32'(mdu_op), 32'(vecs[i].mop));
            checkOutput($sformatf("v%0d.d1", i), mdu_d1, vecs[i].d1);
            checkOutput($sformatf("v%0d.d2", i), mdu_d2, vecs[i].d2);
            checkOutput($sformatf("v%0d.err", i), 32'(err_proto), 32'(vecs[i].err));
            checkOutput($sformatf("v%0d.bc", i), busy_cycles, vecs[i].bc);
            tick();
        end

        // DIV followed by MFLO held valid: stalls through LAUNCH and 10 RUN cycles
        doReset();
        applyStimulus(1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
        checkOutput("div.accept", 32'(req_ready), 32'd1);
        tick();
        applyStimulus(1'b1, 4'd9, 32'd0, 32'd0, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            checkOutput($sformatf("div.stall%0d", c), 32'(stall), 32'd1);
            tick();
        end
        checkOutput("div.mflo_ready", 32'(req_ready), 32'd1);
        checkOutput("div.mflo_stall", 32'(stall), 32'd0);
        checkOutput("div.bc", busy_cycles, 32'd10);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("div.after_mflo", 32'(req_ready), 32'd1);
        checkOutput("div.err", 32'(err_proto), 32'd0);

        // MDU busy tied low: mismatch from the first RUN cycle, sticky until reset
        doReset();
        tie_low = 1'b1;
        applyStimulus(1'b1, 4'd2, 32'd3, 32'd4, 1'b0);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("tie.err_launch", 32'(err_proto), 32'd0);
        tick();
        checkOutput("tie.err_run", 32'(err_proto), 32'd1);
        for (int c = 0; c < 7; c++) tick();
        checkOutput("tie.idle", 32'(req_ready), 32'd1);
        checkOutput("tie.err_sticky", 32'(err_proto), 32'd1);
        tie_low = 1'b0;
        doReset();
        checkOutput("tie.err_cleared", 32'(err_proto), 32'd0);

`ifdef MDU_CANCEL_EN
        // Flush blocks acceptance in IDLE and kills the op in LAUNCH
        applyStimulus(1'b1, 4'd1, 32'd1, 32'd2, 1'b1);
        checkOutput("cx.idle_ready", 32'(req_ready), 32'd0);
        checkOutput("cx.idle_stall", 32'(stall), 32'd1);
        tick();
        applyStimulus(1'b1, 4'd4, 32'd100, 32'd7, 1'b0);
        checkOutput("cx.not_taken", 32'(req_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        checkOutput("cx.launch_start", 32'(mdu_start), 32'd0);
        checkOutput("cx.launch_op", 32'(mdu_op), 32'd0);
        tick();
        applyStimulus(1'b1, 4'd4, 32'd100, 32'd7, 1'b0);
        checkOutput("cx.back_idle", 32'(req_ready), 32'd1);
        checkOutput("cx.err", 32'(err_proto), 32'd0);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("cx.run_start", 32'(mdu_start), 32'd1);
        tick();
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, c < 3);
            checkOutput($sformatf("cx.run%0d", c), 32'(req_ready), 32'd0);
            tick();
        end
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("cx.done", 32'(req_ready), 32'd1);
        checkOutput("cx.bc", busy_cycles, 32'd10);
        checkOutput("cx.err_end", 32'(err_proto), 32'd0);
`else
        // Flush has no effect: request taken in IDLE and started in LAUNCH
        applyStimulus(1'b1, 4'd1, 32'd1, 32'd2, 1'b1);
        checkOutput("nf.idle_ready", 32'(req_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        checkOutput("nf.start", 32'(mdu_start), 32'd1);
        checkOutput("nf.op", 32'(mdu_op), 32'd1);
        for (int c = 0; c < 6; c++) tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("nf.done", 32'(req_ready), 32'd1);
        checkOutput("nf.bc", busy_cycles, 32'd5);
`endif

        // Reset in the middle of RUN with cnt==3, then a fresh MULT
        doReset();
        applyStimulus(1'b1, 4'd1, 32'd9, 32'd9, 1'b0);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, 4'd1, 32'd11, 32'd22, 1'b0);
        checkOutput("rr.ready", 32'(req_ready), 32'd1);
        checkOutput("rr.start", 32'(mdu_start), 32'd0);
        checkOutput("rr.op", 32'(mdu_op), 32'd0);
        checkOutput("rr.d1", mdu_d1, 32'd0);
        checkOutput("rr.err", 32'(err_proto), 32'd0);
        checkOutput("rr.bc", busy_cycles, 32'd0);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("rr.new_start", 32'(mdu_start), 32'd1);
        checkOutput("rr.new_d1", mdu_d1, 32'd11);
        checkOutput("rr.new_d2", mdu_d2, 32'd22);
        for (int c = 0; c < 6; c++) tick();
        checkOutput("rr.new_done", 32'(req_ready), 32'd1);
        checkOutput("rr.new_bc", busy_cycles, 32'd5);
        checkOutput("rr.new_err", 32'(err_proto), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
